rmii_tx_framer: RTL

- Transmit-side Ethernet framer for the 50 MHz RMII interface (txen/txd) on the Nexys A7 Ethernet path.
- Accepts a payload byte stream over a valid/ready handshake, runs entirely in the 50 MHz RMII clock domain, and serialises one frame onto 2-bit txd.
- Frame = preamble + SFD + payload + zero padding + CRC-32 FCS, followed by the inter-frame gap.
- Complements the RMII receive path so cores can originate frames (e.g. read responses).

---
 rtl/rmii_tx_framer.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rmii_tx_framer.sv
// RMII transmit framer: wraps a streamed payload in preamble, SFD, zero padding
// and a CRC-32 FCS, then serialises the frame two bits per 50 MHz clock.
module rmii_tx_framer #(
   parameter int PREAMBLE_BYTES  = 7,
   parameter int MIN_FRAME_BYTES = 60,
   parameter int IFG_CYCLES      = 48
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       txen,
   output logic [1:0] txd,
   output logic       busy,
   output logic       frame_done,
   output logic       underflow
);

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      SFD,
      DATA,
      PAD,
      FCS,
      IFG
   } state_t;

   localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BYTES - 1);
   localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
   localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
   localparam logic [7:0]  PRE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE = 8'hD5;

   // Frame position: state plus which dibit of cur_byte is currently on txd.
   state_t      state, state_n;
   logic [1:0]  dcnt, dcnt_n;
   logic [7:0]  cur_byte, cur_byte_n;
   logic [10:0] byte_cnt, byte_cnt_n;
   logic [1:0]  fcs_cnt, fcs_cnt_n;
   logic [15:0] ifg_cnt, ifg_cnt_n;
   logic [31:0] crc, crc_n;
   logic        last_seen, last_seen_n;
   logic        txen_n;
   logic [1:0]  txd_n;
   logic        frame_done_n;

   logic        byte_end;
   logic [1:0]  dcnt_inc;
   logic        load_en;
   logic [7:0]  load_val;

   // Reflected CRC-32 advanced by one whole byte (LSB first on the wire).
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   // Next-state, next-output and handshake decode. Every byte boundary either
   // loads the next byte to send or leaves the transmitting states.
   always_comb begin
      state_n      = state;
      dcnt_n       = dcnt;
      cur_byte_n   = cur_byte;
      byte_cnt_n   = byte_cnt;
      fcs_cnt_n    = fcs_cnt;
      ifg_cnt_n    = ifg_cnt;
      crc_n        = crc;
      last_seen_n  = last_seen;
      txen_n       = txen;
      txd_n        = txd;
      frame_done_n = 1'b0;
      in_ready     = 1'b0;
      underflow    = 1'b0;
      load_en      = 1'b0;
      load_val     = 8'h00;
      byte_end     = (dcnt == 2'd3);
      dcnt_inc     = dcnt + 2'd1;

      if ((state inside {PREAMBLE, SFD, DATA, PAD, FCS}) && !byte_end) begin
         dcnt_n = dcnt_inc;
         txd_n  = cur_byte[{dcnt_inc, 1'b0} +: 2];
      end

      case (state)
         IDLE: begin
            txen_n = 1'b0;
            txd_n  = 2'b00;
            if (in_valid) begin
               state_n     = PREAMBLE;
               byte_cnt_n  = '0;
               crc_n       = CRC_INIT;
               last_seen_n = 1'b0;
               load_en     = 1'b1;
               load_val    = PRE_BYTE;
            end
         end

         PREAMBLE: begin
            if (byte_end) begin
               load_en = 1'b1;
               if (byte_cnt == PRE_LAST) begin
                  state_n  = SFD;
                  load_val = SFD_BYTE;
               end else begin
                  byte_cnt_n = byte_cnt + 11'd1;
                  load_val   = PRE_BYTE;
               end
            end
         end

         // Starvation right after the SFD is treated the same as mid-payload
         // starvation: the frame is abandoned without an FCS.
         SFD: begin
            if (byte_end) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  state_n     = DATA;
                  load_en     = 1'b1;
                  load_val    = in_data;
                  crc_n       = crc_byte(crc, in_data);
                  byte_cnt_n  = 11'd1;
                  last_seen_n = in_last;
               end else begin
                  underflow = 1'b1;
                  state_n   = IFG;
                  ifg_cnt_n = '0;
                  txen_n    = 1'b0;
                  txd_n     = 2'b00;
               end
            end
         end

         DATA: begin
            if (byte_end) begin
               if (!last_seen) begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     load_en     = 1'b1;
                     load_val    = in_data;
                     crc_n       = crc_byte(crc, in_data);
                     byte_cnt_n  = (byte_cnt < MIN_CNT) ? byte_cnt + 11'd1 : byte_cnt;
                     last_seen_n = in_last;
                  end else begin
                     underflow = 1'b1;
                     state_n   = IFG;
                     ifg_cnt_n = '0;
                     txen_n    = 1'b0;
                     txd_n     = 2'b00;
                  end
               end else if (byte_cnt < MIN_CNT) begin
                  state_n    = PAD;
                  load_en    = 1'b1;
                  load_val   = 8'h00;
                  crc_n      = crc_byte(crc, 8'h00);
                  byte_cnt_n = byte_cnt + 11'd1;
               end else begin
                  state_n   = FCS;
                  load_en   = 1'b1;
                  load_val  = ~crc[7:0];
                  crc_n     = {8'hFF, crc[31:8]};
                  fcs_cnt_n = '0;
               end
            end
         end

         PAD: begin
            if (byte_end) begin
               load_en = 1'b1;
               if (byte_cnt < MIN_CNT) begin
                  load_val   = 8'h00;
                  crc_n      = crc_byte(crc, 8'h00);
                  byte_cnt_n = byte_cnt + 11'd1;
               end else begin
                  state_n   = FCS;
                  load_val  = ~crc[7:0];
                  crc_n     = {8'hFF, crc[31:8]};
                  fcs_cnt_n = '0;
               end
            end
         end

         // The CRC register is shifted down a byte at a time so its low byte
         // always holds the next (inverted) FCS byte.
         FCS: begin
            if (byte_end) begin
               if (fcs_cnt == 2'd3) begin
                  state_n      = IFG;
                  ifg_cnt_n    = '0;
                  txen_n       = 1'b0;
                  txd_n        = 2'b00;
                  frame_done_n = 1'b1;
               end else begin
                  load_en   = 1'b1;
                  load_val  = ~crc[7:0];
                  crc_n     = {8'hFF, crc[31:8]};
                  fcs_cnt_n = fcs_cnt + 2'd1;
               end
            end
         end

         IFG: begin
            txen_n = 1'b0;
            txd_n  = 2'b00;
            if (ifg_cnt == IFG_LAST) begin
               state_n = IDLE;
            end else begin
               ifg_cnt_n = ifg_cnt + 16'd1;
            end
         end

         default: begin
            state_n = IDLE;
            txen_n  = 1'b0;
            txd_n   = 2'b00;
         end
      endcase

      if (load_en) begin
         cur_byte_n = load_val;
         dcnt_n     = 2'd0;
         txen_n     = 1'b1;
         txd_n      = load_val[1:0];
      end
   end

   // State and registered RMII outputs; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dcnt       <= '0;
         cur_byte   <= '0;
         byte_cnt   <= '0;
         fcs_cnt    <= '0;
         ifg_cnt    <= '0;
         crc        <= CRC_INIT;
         last_seen  <= 1'b0;
         txen       <= 1'b0;
         txd        <= 2'b00;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         dcnt       <= dcnt_n;
         cur_byte   <= cur_byte_n;
         byte_cnt   <= byte_cnt_n;
         fcs_cnt    <= fcs_cnt_n;
         ifg_cnt    <= ifg_cnt_n;
         crc        <= crc_n;
         last_seen  <= last_seen_n;
         txen       <= txen_n;
         txd        <= txd_n;
         frame_done <= frame_done_n;
      end
   end

   assign busy = (state != IDLE);

endmodule
